uart_tx_fifo: RTL and testbench

Parametrised UART transmitter with an input FIFO, configurable data width, parity and stop bits. It replaces the fixed 8N1 transmitter in the case-converter datapath. It sits between the converter logic, which pushes characters, and the serial pin. Bit timing comes from the shared baud generator tick. The FIFO accepts writes on any clock and decouples the producer from the baud rate; consecutive frames are sent back-to-back with no idle gap.

---
 rtl/uart_tx_fifo.sv | 200 ++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a small FIFO.
// Data width, parity mode and stop-bit count are set by parameters.
// The FIFO takes a push on any clock. The serializer moves one line bit per
// i_baud_tick and sends queued frames back-to-back with no idle gap.
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic                               i_baud_tick,
    input  logic [DATA_BITS-1:0]               i_data,
    input  logic                               i_valid,
    output logic                               o_ready,
    output logic                               o_out,
    output logic                               o_busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_fifo_count
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int IDX_W = $clog2(DATA_BITS);

    // Each state is named after the line bit it is currently driving.
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    // FIFO storage and bookkeeping
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wrPtr;
    logic [PTR_W-1:0]     r_rdPtr;
    logic [CNT_W-1:0]     r_count;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;

    // Serializer state
    state_t               r_state;
    state_t               w_nextState;
    logic [DATA_BITS-1:0] r_word;
    logic [IDX_W-1:0]     r_idx;
    logic [IDX_W-1:0]     w_nextIdx;
    logic [IDX_W-1:0]     w_idxInc;
    logic [1:0]           r_stopCnt;
    logic [1:0]           w_nextStopCnt;
    logic                 r_out;
    logic                 w_nextOut;
    logic                 r_busy;
    logic                 w_nextBusy;
    logic                 w_parityBit;
    logic                 w_lastData;
    logic                 w_lastStop;

    // o_ready depends only on the registered count.
    // A pop in the same cycle does not free a slot early.
    assign w_full   = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty  = (r_count == '0);
    assign o_ready  = !w_full;
    assign w_push   = i_valid && !w_full;

    assign o_out        = r_out;
    assign o_busy       = r_busy;
    assign o_fifo_count = r_count;

    assign w_idxInc   = r_idx + IDX_W'(1);
    assign w_lastData = (r_idx == IDX_W'(DATA_BITS - 1));
    assign w_lastStop = (r_stopCnt == 2'(STOP_BITS));

    // Odd parity makes the total count of ones odd; even parity makes it even.
    assign w_parityBit = (PARITY == 1) ? ~(^r_word) : (^r_word);

    // FIFO storage is written on accepted pushes. It needs no reset because
    // the pointers and count determine which entries are valid.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    // The FIFO pointers and occupancy count follow pushes and pops.
    // A simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Serializer registers: state, bit index, stop counter, line and busy flag.
    // The popped word is latched here.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_stopCnt <= '0;
            r_out     <= 1'b1;
            r_busy    <= 1'b0;
            r_word    <= '0;
        end else begin
            r_state   <= w_nextState;
            r_idx     <= w_nextIdx;
            r_stopCnt <= w_nextStopCnt;
            r_out     <= w_nextOut;
            r_busy    <= w_nextBusy;
            if (w_pop) begin
                r_word <= r_mem[r_rdPtr];
            end
        end
    end

    // Next-state logic advances one line bit per baud tick.
    // A pop happens only when a new frame starts.
    always_comb begin
        w_nextState   = r_state;
        w_nextIdx     = r_idx;
        w_nextStopCnt = r_stopCnt;
        w_nextOut     = r_out;
        w_nextBusy    = r_busy;
        w_pop         = 1'b0;
        if (i_baud_tick) begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_nextState = S_START;
                        w_nextOut   = 1'b0;
                        w_nextBusy  = 1'b1;
                    end
                end
                S_START: begin
                    w_nextState = S_DATA;
                    w_nextIdx   = '0;
                    w_nextOut   = r_word[0];
                end
                S_DATA: begin
                    if (w_lastData) begin
                        if (PARITY != 0) begin
                            w_nextState = S_PAR;
                            w_nextOut   = w_parityBit;
                        end else begin
                            w_nextState   = S_STOP;
                            w_nextStopCnt = 2'd1;
                            w_nextOut     = 1'b1;
                        end
                    end else begin
                        w_nextIdx = w_idxInc;
                        w_nextOut = r_word[w_idxInc];
                    end
                end
                S_PAR: begin
                    w_nextState   = S_STOP;
                    w_nextStopCnt = 2'd1;
                    w_nextOut     = 1'b1;
                end
                S_STOP: begin
                    if (w_lastStop) begin
                        if (!w_empty) begin
                            w_pop       = 1'b1;
                            w_nextState = S_START;
                            w_nextOut   = 1'b0;
                        end else begin
                            w_nextState = S_IDLE;
                            w_nextOut   = 1'b1;
                            w_nextBusy  = 1'b0;
                        end
                    end else begin
                        w_nextStopCnt = r_stopCnt + 2'd1;
                    end
                end
                default: begin
                    w_nextState = S_IDLE;
                    w_nextOut   = 1'b1;
                    w_nextBusy  = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: drives two transmitter instances, one 8N1 and one 7E2,
// with the same push and tick stream.
// Each instance has a frame-level reference model: a FIFO queue plus a queue of line bits.
module tb_uart_tx_fifo;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       valid;
    logic [7:0] data;
    logic [6:0] dataB;

    logic       readyA, outA, busyA;
    logic [2:0] countA;
    logic       readyB, outB, busyB;
    logic [2:0] countB;

    int  fifoA[$];
    int  fifoB[$];
    bit  lineA[$];
    bit  lineB[$];
    bit  expOutA, expBusyA, expOutB, expBusyB;

    int  checkCount = 0;
    int  passCount  = 0;

    assign dataB = data[6:0];

    always #5 clk = ~clk;

    uart_tx_fifo #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dutA (
        .i_clk(clk), .i_rst(rst), .i_baud_tick(tick), .i_data(data), .i_valid(valid),
        .o_ready(readyA), .o_out(outA), .o_busy(busyA), .o_fifo_count(countA)
    );

    uart_tx_fifo #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) dutB (
        .i_clk(clk), .i_rst(rst), .i_baud_tick(tick), .i_data(dataB), .i_valid(valid),
        .o_ready(readyB), .o_out(outB), .o_busy(busyB), .o_fifo_count(countB)
    );

    // Advance one instance's model by one clock edge.
    // A tick either shifts out the next queued line bit or starts a new frame from the FIFO.
    // A push is accepted only if the FIFO was not full before the edge.
    task automatic modelStep(input int dBits, input int par, input int stops,
                             input bit vld, input int word, input bit tk,
                             ref int fifoQ[$], ref bit lineQ[$],
                             ref bit expOut, ref bit expBusy);
        bit canPush;
        int w;
        int ones;
        bit b;
        canPush = (fifoQ.size() != DEPTH);
        if (tk) begin
            if (lineQ.size() != 0) begin
                expOut = lineQ.pop_front();
            end else if (fifoQ.size() != 0) begin
                w = fifoQ.pop_front();
                ones = 0;
                lineQ.push_back(1'b0);
                for (int i = 0; i < dBits; i++) begin
                    b = bit'((w >> i) & 1);
                    lineQ.push_back(b);
                    ones += int'(b);
                end
                if (par == 1) lineQ.push_back((ones % 2) == 0);
                if (par == 2) lineQ.push_back((ones % 2) == 1);
                for (int i = 0; i < stops; i++) lineQ.push_back(1'b1);
                expOut  = lineQ.pop_front();
                expBusy = 1'b1;
            end else begin
                expOut  = 1'b1;
                expBusy = 1'b0;
            end
        end
        if (vld && canPush) fifoQ.push_back(word & ((1 << dBits) - 1));
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input int exp);
        logic [31:0] expv;
        expv = exp;
        checkCount++;
        assert (obs === expv) passCount++;
        else $error("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, expv, $time);
    endtask

    task automatic checkAll();
        checkOutput("A.out",   {31'd0, outA},   int'(expOutA));
        checkOutput("A.busy",  {31'd0, busyA},  int'(expBusyA));
        checkOutput("A.count", {29'd0, countA}, fifoA.size());
        checkOutput("A.ready", {31'd0, readyA}, int'(fifoA.size() != DEPTH));
        checkOutput("B.out",   {31'd0, outB},   int'(expOutB));
        checkOutput("B.busy",  {31'd0, busyB},  int'(expBusyB));
        checkOutput("B.count", {29'd0, countB}, fifoB.size());
        checkOutput("B.ready", {31'd0, readyB}, int'(fifoB.size() != DEPTH));
    endtask

    // Drive one cycle of inputs, predict its edge, then check after the edge.
    task automatic applyStimulus(input bit vld, input logic [7:0] d, input bit tk);
        valid = vld;
        data  = d;
        tick  = tk;
        modelStep(8, 0, 1, vld, int'(d), tk, fifoA, lineA, expOutA, expBusyA);
        modelStep(7, 2, 2, vld, int'(d), tk, fifoB, lineB, expOutB, expBusyB);
        @(posedge clk);
        @(negedge clk);
        checkAll();
    endtask

    task automatic idleRun(input int nTicks, input int period);
        for (int k = 0; k < nTicks; k++) begin
            for (int c = 0; c < period; c++) begin
                applyStimulus(1'b0, 8'h00, c == period - 1);
            end
        end
    endtask

    task automatic resetModels();
        fifoA.delete(); fifoB.delete(); lineA.delete(); lineB.delete();
        expOutA = 1'b1; expBusyA = 1'b0; expOutB = 1'b1; expBusyB = 1'b0;
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; tick = 1'b0; data = 8'h00;
        resetModels();
        #1 checkAll();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkAll();

        $display("[TB] idle ticks with empty FIFO");
        applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1);

        $display("[TB] single word 0x55, tick every 16 clocks");
        applyStimulus(1'b1, 8'h55, 1'b0);
        idleRun(14, 16);

        $display("[TB] single word 0x41 with parity");
        applyStimulus(1'b1, 8'h41, 1'b0);
        idleRun(14, 4);

        $display("[TB] push and tick in the same cycle");
        applyStimulus(1'b1, 8'h6B, 1'b1);
        idleRun(14, 2);

        $display("[TB] back-to-back 0x00 then 0xFF");
        applyStimulus(1'b1, 8'h00, 1'b0);
        applyStimulus(1'b1, 8'hFF, 1'b0);
        idleRun(26, 3);

        $display("[TB] fill FIFO without ticks, then pop one");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 8'hA0 + 8'(i), 1'b0);
        end
        applyStimulus(1'b1, 8'hEE, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        idleRun(60, 2);

        $display("[TB] reset during data bit 3");
        applyStimulus(1'b1, 8'h3C, 1'b0);
        applyStimulus(1'b1, 8'hC3, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'h00, 1'b1);
        #2 rst = 1'b1;
        resetModels();
        #1 checkAll();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkAll();
        idleRun(12, 1);
        applyStimulus(1'b1, 8'h5A, 1'b0);
        idleRun(14, 2);

        $display("[TB] random pushes and ticks");
        for (int i = 0; i < 800; i++) begin
            applyStimulus($urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 5) == 0);
        end
        idleRun(64, 1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
